// File: rtl/i2c_master_seq.sv
// I2C master transaction sequencer: START, address + R/W, N data bytes with ACK/NACK, STOP.
// SCL is derived from clk; both pads are driven as open-drain pull-down enables.
module i2c_master_seq #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_len,
    output logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_STOP
    } state_t;

    state_t     state, state_nx;
    logic [7:0] div_cnt;
    logic       tick;
    logic [1:0] phase;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] bytes_left;
    logic       rw_q;
    logic       ack_nak;
    logic       nack_pend;
    logic       accept;
    logic       in_frame;
    logic       frame_end;
    logic       tx_bit;

    // cmd_valid/cmd_ready: a command transfers on a rising edge where both are high.
    // cmd_ready is high exactly while idle; cmd_* are ignored at all other times.
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = !cmd_ready || done || accept;
    assign tick      = (state != S_IDLE) && (div_cnt == TICK_LAST);
    assign in_frame  = (state == S_ADDR) || (state == S_WRITE) || (state == S_READ);
    assign frame_end = tick && (phase == 2'd3) && (bit_cnt == 4'd8);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_START;
            S_START: if (tick && phase == 2'd3) state_nx = S_ADDR;
            S_ADDR: begin
                if (frame_end) begin
                    if (ack_nak || bytes_left == 4'd0) state_nx = S_STOP;
                    else if (rw_q)                     state_nx = S_READ;
                    else                               state_nx = S_WRITE;
                end
            end
            S_WRITE: if (frame_end && (ack_nak || bytes_left == 4'd1)) state_nx = S_STOP;
            S_READ:  if (frame_end && bytes_left == 4'd1) state_nx = S_STOP;
            S_STOP:  if (tick && phase == 2'd3) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The first write byte bit is taken straight from wr_data so SDA is valid on the load cycle.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        wr_req = (state == S_WRITE) && (bit_cnt == 4'd0) && (phase == 2'd0) && (div_cnt == 8'd0);
        tx_bit = wr_req ? wr_data[7] : shreg[7];
        case (state)
            S_START: begin
                sda_oe = (phase != 2'd0);
                scl_oe = phase[1];
            end
            S_ADDR, S_WRITE: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = (bit_cnt != 4'd8) && !tx_bit;
            end
            S_READ: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = (bit_cnt == 4'd8) && (bytes_left != 4'd1);
            end
            S_STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase < 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            div_cnt    <= 8'd0;
            phase      <= 2'd0;
            bit_cnt    <= 4'd0;
            shreg      <= 8'd0;
            bytes_left <= 4'd0;
            rw_q       <= 1'b0;
            ack_nak    <= 1'b0;
            nack_pend  <= 1'b0;
            nack       <= 1'b0;
            done       <= 1'b0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
        end else begin
            state    <= state_nx;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            if (accept) begin
                div_cnt    <= 8'd0;
                phase      <= 2'd0;
                bit_cnt    <= 4'd0;
                shreg      <= {cmd_addr, cmd_rw};
                bytes_left <= cmd_len;
                rw_q       <= cmd_rw;
                nack_pend  <= 1'b0;
                nack       <= 1'b0;
            end else if (state != S_IDLE) begin
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                if (wr_req) shreg <= wr_data;
                if (tick) begin
                    phase <= phase + 2'd1;
                    // SCL has been high through p1/p2, so the end of p2 is the sample point
                    if (phase == 2'd2 && in_frame) begin
                        if (bit_cnt == 4'd8) begin
                            ack_nak <= sda_i;
                        end else if (state == S_READ) begin
                            shreg <= {shreg[6:0], sda_i};
                            if (bit_cnt == 4'd7) begin
                                rd_data  <= {shreg[6:0], sda_i};
                                rd_valid <= 1'b1;
                            end
                        end
                    end
                    if (phase == 2'd3 && in_frame) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state != S_ADDR) bytes_left <= bytes_left - 4'd1;
                            if (state != S_READ && ack_nak) nack_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state != S_READ) shreg <= {shreg[6:0], 1'b0};
                        end
                    end
                    if (phase == 2'd3 && state == S_STOP) begin
                        done <= 1'b1;
                        nack <= nack_pend;
                    end
                end
            end
        end
    end

endmodule
